// File: rtl/cache_pkg.sv
// Shared types and default sizes for the direct-mapped cache controller.
// Imported by cache_ctrl_if, cache_entry and cache_ctrl.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    MEM_WR,
    RESP
  } state_t;

  localparam int LINES_DEF  = 4;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int HIT_CNT_W  = 16;

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU request/response and backing-store bus of the cache controller.
// slave = controller side, master = requester/memory side.
interface cache_ctrl_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cpu_valid;
  logic              cpu_ready;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;

  logic              rsp_valid;
  logic              rsp_hit;
  logic [DATA_W-1:0] rsp_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_valid, cpu_write, cpu_addr, cpu_wdata,
    input  mem_ack, mem_rdata,
    output cpu_ready, rsp_valid, rsp_hit, rsp_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_valid, cpu_write, cpu_addr, cpu_wdata,
    output mem_ack, mem_rdata,
    input  cpu_ready, rsp_valid, rsp_hit, rsp_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_entry.sv
// One direct-mapped line: valid/tag/data registers with a write port
// and a combinational tag compare.
module cache_entry
  import cache_pkg::*;
#(
  parameter int TAG_W  = 6,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [TAG_W-1:0]  tag,
  input  logic [DATA_W-1:0] wr_data,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic             valid;
  logic [TAG_W-1:0] tag_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) valid <= 1'b0;
    else if (we)  valid <= 1'b1;
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clock) begin
    if (we) begin
      tag_q <= tag;
      data  <= wr_data;
    end
  end

  assign hit = valid && (tag_q == tag);

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through/write-allocate cache controller.
// Define CACHE_CTRL_HIT_COUNT_EN to build the saturating hit counter.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int LINES  = LINES_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  cache_ctrl_if.slave          bus,
  output logic [HIT_CNT_W-1:0] hit_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  state_t state, state_nx;

  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic              hit_q;

  logic              accept;
  logic              fill;
  logic              wr_alloc;
  logic              lk_hit;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [LINES-1:0]  line_hit;
  logic [DATA_W-1:0] line_data [LINES];
  logic [DATA_W-1:0] fill_data;

  assign idx       = req_addr[IDX_W-1:0];
  assign tag       = req_addr[ADDR_W-1:IDX_W];
  assign lk_hit    = line_hit[idx];
  assign fill_data = fill ? bus.mem_rdata : req_wdata;

  for (genvar i = 0; i < LINES; i++) begin : g_line
    cache_entry #(
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
    ) u_entry (
      .clock   (clock),
      .reset_n (reset_n),
      .we      ((fill || wr_alloc) && (idx == IDX_W'(i))),
      .tag     (tag),
      .wr_data (fill_data),
      .hit     (line_hit[i]),
      .data    (line_data[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    accept        = 1'b0;
    fill          = 1'b0;
    wr_alloc      = 1'b0;
    bus.cpu_ready = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.cpu_ready = 1'b1;
        if (bus.cpu_valid) begin
          accept   = 1'b1;
          state_nx = LOOKUP;
        end
      end
      LOOKUP: begin
        if (req_write) begin
          wr_alloc = 1'b1;
          state_nx = MEM_WR;
        end else if (lk_hit) begin
          state_nx = RESP;
        end else begin
          state_nx = MEM_RD;
        end
      end
      MEM_RD: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          fill     = 1'b1;
          state_nx = RESP;
        end
      end
      MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_ack) state_nx = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Response fields only change on entry to RESP, so they hold between responses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_addr      <= '0;
      req_write     <= 1'b0;
      req_wdata     <= '0;
      hit_q         <= 1'b0;
      bus.rsp_hit   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      if (accept) begin
        req_addr  <= bus.cpu_addr;
        req_write <= bus.cpu_write;
        req_wdata <= bus.cpu_wdata;
      end
      if (state == LOOKUP) hit_q <= lk_hit;
      if (state == LOOKUP && !req_write && lk_hit) begin
        bus.rsp_hit   <= 1'b1;
        bus.rsp_rdata <= line_data[idx];
      end
      if (fill) begin
        bus.rsp_hit   <= 1'b0;
        bus.rsp_rdata <= bus.mem_rdata;
      end
      if (state == MEM_WR && bus.mem_ack) begin
        bus.rsp_hit   <= hit_q;
        bus.rsp_rdata <= req_wdata;
      end
    end
  end

  assign bus.mem_addr  = req_addr;
  assign bus.mem_wdata = req_wdata;

`ifdef CACHE_CTRL_HIT_COUNT_EN
  logic [HIT_CNT_W-1:0] hit_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q <= '0;
    end else if (bus.rsp_valid && bus.rsp_hit && hit_cnt_q != '1) begin
      hit_cnt_q <= hit_cnt_q + HIT_CNT_W'(1);
    end
  end

  assign hit_count = hit_cnt_q;
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl (LINES=4, ADDR_W=8, DATA_W=32)
// against an array-based cache/memory model.
module tb_cache_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] hit_count;

  int n_checks = 0;
  int n_pass   = 0;

  cache_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  cache_ctrl #(
    .LINES  (4),
    .ADDR_W (8),
    .DATA_W (32)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .hit_count (hit_count)
  );

  always #5 clock = ~clock;

  // Behavioural model: line arrays indexed by addr%4, tag addr/4.
  logic [31:0] mem [256];
  bit          m_valid [4];
  int          m_tag [4];
  logic [31:0] m_data [4];
  int          m_hits;

  // Results of the last request.
  bit          r_tmo, r_hit, r_seen, r_we, r_stable, r_pulse;
  logic [31:0] r_rd, r_wd;
  logic [7:0]  r_addr;
  int          r_lat;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_valid[i] = 0;
    m_hits = 0;
  endtask

  task automatic model_access(input bit w, input logic [7:0] a,
                              input logic [31:0] wd,
                              output bit eh, output logic [31:0] ed);
    int i;
    int t;
    i  = int'(a) % 4;
    t  = int'(a) / 4;
    eh = m_valid[i] && m_tag[i] == t;
    if (w) begin
      mem[a]    = wd;
      m_valid[i] = 1;
      m_tag[i]   = t;
      m_data[i]  = wd;
      ed         = wd;
    end else if (eh) begin
      ed = m_data[i];
    end else begin
      ed         = mem[a];
      m_valid[i] = 1;
      m_tag[i]   = t;
      m_data[i]  = mem[a];
    end
    if (eh && m_hits < 65535) m_hits++;
  endtask

  function automatic logic [15:0] exp_hc();
`ifdef CACHE_CTRL_HIT_COUNT_EN
    return 16'(m_hits);
`else
    return 16'd0;
`endif
  endfunction

  // Drives one request and acts as the backing store; records what it saw.
  task automatic run_req(input bit w, input logic [7:0] a,
                         input logic [31:0] wd, input int dly);
    int mc;
    mc = 0;
    r_tmo = 1; r_hit = 0; r_rd = 0; r_seen = 0; r_we = 0;
    r_addr = 0; r_wd = 0; r_stable = 1; r_pulse = 0; r_lat = 0;
    @(negedge clock);
    bus.cpu_valid = 1;
    bus.cpu_write = w;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    @(posedge clock); #1;
    bus.cpu_valid = 0;
    r_lat = 1;
    for (int c = 0; c < 64; c++) begin
      if (bus.rsp_valid) begin
        r_tmo = 0;
        r_hit = bus.rsp_hit;
        r_rd  = bus.rsp_rdata;
        if (bus.mem_req) r_stable = 0;
        @(posedge clock); #1;
        r_pulse = !bus.rsp_valid && bus.cpu_ready &&
                  bus.rsp_hit === r_hit && bus.rsp_rdata === r_rd;
        break;
      end
      if (bus.mem_req) begin
        if (!r_seen) begin
          r_seen = 1;
          r_we   = bus.mem_we;
          r_addr = bus.mem_addr;
          r_wd   = bus.mem_wdata;
        end else if (bus.mem_we !== r_we || bus.mem_addr !== r_addr ||
                     bus.mem_wdata !== r_wd) begin
          r_stable = 0;
        end
        mc++;
        if (mc > dly) begin
          bus.mem_ack   = 1;
          bus.mem_rdata = bus.mem_we ? $urandom : mem[bus.mem_addr];
        end
      end
      @(posedge clock); #1;
      bus.mem_ack = 0;
      r_lat++;
    end
  endtask

  task automatic test_reset();
    bus.cpu_valid = 0; bus.cpu_write = 0; bus.cpu_addr = 0;
    bus.cpu_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    reset_n = 0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    #1;
    n_checks++;
    if ({bus.cpu_ready, bus.rsp_valid, bus.rsp_hit, bus.mem_req, bus.mem_we} !== 5'b10000)
      $display("FAIL reset_ctl got=%b exp=10000",
               {bus.cpu_ready, bus.rsp_valid, bus.rsp_hit, bus.mem_req, bus.mem_we});
    else n_pass++;
    n_checks++;
    if (bus.rsp_rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", bus.rsp_rdata);
    else n_pass++;
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== 40'h0)
      $display("FAIL reset_mem got=%h/%h exp=0/0", bus.mem_addr, bus.mem_wdata);
    else n_pass++;
    n_checks++;
    if (hit_count !== 16'h0) $display("FAIL reset_hitcnt got=%0d exp=0", hit_count);
    else n_pass++;
  endtask

  task automatic test_read_miss_hit();
    bit eh;
    logic [31:0] ed;
    model_access(0, 8'h05, 0, eh, ed);
    run_req(0, 8'h05, 32'h0, 3);
    n_checks++;
    if (r_tmo !== 0) $display("FAIL rd05_miss_timeout got=%0d exp=0", r_tmo);
    else n_pass++;
    n_checks++;
    if ({r_hit, r_rd} !== {1'b0, 32'hDEADBEEF})
      $display("FAIL rd05_miss_rsp got=%0d/%h exp=0/deadbeef", r_hit, r_rd);
    else n_pass++;
    n_checks++;
    if ({r_seen, r_we, r_addr, r_stable} !== {1'b1, 1'b0, 8'h05, 1'b1})
      $display("FAIL rd05_miss_mem got=%0d/%0d/%h/%0d exp=1/0/05/1",
               r_seen, r_we, r_addr, r_stable);
    else n_pass++;
    n_checks++;
    if (r_pulse !== 1) $display("FAIL rd05_miss_pulse got=%0d exp=1", r_pulse);
    else n_pass++;
    model_access(0, 8'h05, 0, eh, ed);
    run_req(0, 8'h05, 32'h0, 0);
    n_checks++;
    if ({r_tmo, r_hit, r_rd} !== {1'b0, 1'b1, 32'hDEADBEEF})
      $display("FAIL rd05_hit_rsp got=%0d/%0d/%h exp=0/1/deadbeef", r_tmo, r_hit, r_rd);
    else n_pass++;
    n_checks++;
    if (r_seen !== 0) $display("FAIL rd05_hit_memreq got=%0d exp=0", r_seen);
    else n_pass++;
    n_checks++;
    if (r_lat !== 2) $display("FAIL rd05_hit_latency got=%0d exp=2", r_lat);
    else n_pass++;
  endtask

  task automatic test_conflict();
    bit eh;
    logic [31:0] ed;
    model_access(0, 8'h09, 0, eh, ed);
    run_req(0, 8'h09, 32'h0, 1);
    n_checks++;
    if ({r_tmo, r_hit, r_rd, r_addr} !== {1'b0, 1'b0, mem[9], 8'h09})
      $display("FAIL rd09_miss got=%0d/%0d/%h/%h exp=0/0/%h/09",
               r_tmo, r_hit, r_rd, r_addr, mem[9]);
    else n_pass++;
    model_access(0, 8'h05, 0, eh, ed);
    run_req(0, 8'h05, 32'h0, 2);
    n_checks++;
    if ({r_hit, r_seen, r_rd} !== {1'b0, 1'b1, 32'hDEADBEEF})
      $display("FAIL rd05_evicted got=%0d/%0d/%h exp=0/1/deadbeef", r_hit, r_seen, r_rd);
    else n_pass++;
  endtask

  task automatic test_write();
    bit eh;
    logic [31:0] ed;
    model_access(1, 8'h02, 32'h12345678, eh, ed);
    run_req(1, 8'h02, 32'h12345678, 1);
    n_checks++;
    if ({r_seen, r_we, r_addr, r_wd, r_stable} !== {1'b1, 1'b1, 8'h02, 32'h12345678, 1'b1})
      $display("FAIL wr02_mem got=%0d/%0d/%h/%h/%0d exp=1/1/02/12345678/1",
               r_seen, r_we, r_addr, r_wd, r_stable);
    else n_pass++;
    n_checks++;
    if ({r_tmo, r_hit, r_rd} !== {1'b0, 1'b0, 32'h12345678})
      $display("FAIL wr02_rsp got=%0d/%0d/%h exp=0/0/12345678", r_tmo, r_hit, r_rd);
    else n_pass++;
    model_access(0, 8'h02, 0, eh, ed);
    run_req(0, 8'h02, 32'h0, 0);
    n_checks++;
    if ({r_hit, r_rd, r_seen} !== {1'b1, 32'h12345678, 1'b0})
      $display("FAIL rd02_hit got=%0d/%h/%0d exp=1/12345678/0", r_hit, r_rd, r_seen);
    else n_pass++;
  endtask

  task automatic test_spurious_ack();
    bit eh;
    logic [31:0] ed;
    @(negedge clock);
    bus.mem_ack   = 1;
    bus.mem_rdata = 32'hBAD0BAD0;
    @(posedge clock); #1;
    n_checks++;
    if ({bus.cpu_ready, bus.mem_req, bus.rsp_valid} !== 3'b100)
      $display("FAIL idle_ack got=%b exp=100",
               {bus.cpu_ready, bus.mem_req, bus.rsp_valid});
    else n_pass++;
    bus.mem_ack = 0;
    model_access(1, 8'h02, 32'hCAFEF00D, eh, ed);
    run_req(1, 8'h02, 32'hCAFEF00D, 0);
    n_checks++;
    if ({r_hit, r_rd, r_we} !== {1'b1, 32'hCAFEF00D, 1'b1})
      $display("FAIL wr02_hit got=%0d/%h/%0d exp=1/cafef00d/1", r_hit, r_rd, r_we);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit got_req;
    bit saw_rsp;
    got_req = 0;
    saw_rsp = 0;
    @(negedge clock);
    bus.cpu_valid = 1; bus.cpu_write = 0; bus.cpu_addr = 8'h0D;
    @(posedge clock); #1;
    bus.cpu_valid = 0;
    for (int c = 0; c < 10 && !got_req; c++) begin
      @(posedge clock); #1;
      got_req = bus.mem_req;
    end
    n_checks++;
    if (got_req !== 1) $display("FAIL midrst_memreq_timeout got=%0d exp=1", got_req);
    else n_pass++;
    reset_n = 0;
    model_reset();
    #1;
    n_checks++;
    if ({bus.mem_req, bus.rsp_valid, bus.cpu_ready} !== 3'b001)
      $display("FAIL midrst_async got=%b exp=001",
               {bus.mem_req, bus.rsp_valid, bus.cpu_ready});
    else n_pass++;
    repeat (3) begin
      @(posedge clock); #1;
      if (bus.rsp_valid) saw_rsp = 1;
    end
    @(negedge clock);
    reset_n = 1;
    repeat (3) begin
      @(posedge clock); #1;
      if (bus.rsp_valid) saw_rsp = 1;
    end
    n_checks++;
    if (saw_rsp !== 0) $display("FAIL midrst_rsp got=%0d exp=0", saw_rsp);
    else n_pass++;
  endtask

  task automatic test_hit_count();
    bit          eh;
    logic [31:0] ed;
    bit          w_l [5] = '{0, 0, 0, 0, 1};
    logic [7:0]  a_l [5] = '{8'h05, 8'h05, 8'h05, 8'h06, 8'h06};
    for (int k = 0; k < 5; k++) begin
      model_access(w_l[k], a_l[k], 32'h0BAD0000 + k, eh, ed);
      run_req(w_l[k], a_l[k], 32'h0BAD0000 + k, 1);
      n_checks++;
      if ({r_tmo, r_hit, r_rd} !== {1'b0, eh, ed})
        $display("FAIL hc_seq%0d got=%0d/%0d/%h exp=0/%0d/%h",
                 k, r_tmo, r_hit, r_rd, eh, ed);
      else n_pass++;
    end
    n_checks++;
    if (hit_count !== exp_hc())
      $display("FAIL hit_count_3h2m got=%0d exp=%0d", hit_count, exp_hc());
    else n_pass++;
  endtask

  task automatic test_random();
    bit          w, eh;
    logic [7:0]  a;
    logic [31:0] wd, ed;
    for (int k = 0; k < 60; k++) begin
      w  = ($urandom_range(0, 9) < 3);
      a  = 8'($urandom_range(0, 11));
      wd = $urandom;
      model_access(w, a, wd, eh, ed);
      run_req(w, a, wd, int'($urandom_range(0, 3)));
      n_checks++;
      if ({r_tmo, r_hit, r_rd} !== {1'b0, eh, ed})
        $display("FAIL rnd%0d_rsp a=%h w=%0d got=%0d/%0d/%h exp=0/%0d/%h",
                 k, a, w, r_tmo, r_hit, r_rd, eh, ed);
      else n_pass++;
      n_checks++;
      if (r_seen !== (w || !eh))
        $display("FAIL rnd%0d_memreq got=%0d exp=%0d", k, r_seen, w || !eh);
      else n_pass++;
      if (r_seen) begin
        n_checks++;
        if ({r_we, r_addr, r_stable, r_pulse} !== {w, a, 1'b1, 1'b1})
          $display("FAIL rnd%0d_bus got=%0d/%h/%0d/%0d exp=%0d/%h/1/1",
                   k, r_we, r_addr, r_stable, r_pulse, w, a);
        else n_pass++;
      end
      if (w) begin
        n_checks++;
        if (r_wd !== wd) $display("FAIL rnd%0d_wdata got=%h exp=%h", k, r_wd, wd);
        else n_pass++;
      end
      if (!w && eh) begin
        n_checks++;
        if (r_lat !== 2) $display("FAIL rnd%0d_hit_lat got=%0d exp=2", k, r_lat);
        else n_pass++;
      end
    end
    n_checks++;
    if (hit_count !== exp_hc())
      $display("FAIL hit_count_final got=%0d exp=%0d", hit_count, exp_hc());
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[5] = 32'hDEADBEEF;
    test_reset();
    test_read_miss_hit();
    test_conflict();
    test_write();
    test_spurious_ack();
    test_reset_mid();
    test_hit_count();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1);
  end

endmodule
